// File: rtl/accumulator_pkg.sv
// Shared types and widths for the accumulator write arbiter.
package accumulator_pkg;

  localparam int DEF_LANE_COUNT = 8;
  localparam int DEF_BANK_COUNT = 32;
  localparam int DEF_TILE_SIZE  = 128;
  localparam int DEF_DATA_WIDTH = 8;

  localparam int ROW_W  = $clog2(DEF_TILE_SIZE);
  localparam int BANK_W = $clog2(DEF_BANK_COUNT);

  // One lane holding register: a product waiting for its bank.
  typedef struct packed {
    logic                      valid;
    logic [ROW_W-1:0]          row;
    logic [ROW_W-1:0]          column;
    logic [DEF_DATA_WIDTH-1:0] value;
    logic [BANK_W-1:0]         bank;
  } lane_entry_t;

endpackage

// File: rtl/accumulator_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after pointer,
// scanning upward with wrap at N.
module rr_arbiter #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_index,
  output logic          any_grant
);

  // Scan from the pointer and take the first requester seen.
  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_index  = '0;
    any_grant    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (!any_grant && request[idx]) begin
        any_grant         = 1'b1;
        grant_index       = IW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accumulator_write_arbiter.sv
// Schedules multiplier-lane products into the banked accumulator buffer.
// Each lane holds one product; every bank grants one holder per cycle
// round-robin and the chosen product is written through registered outputs.
module accumulator_write_arbiter
  import accumulator_pkg::*;
#(
  parameter int LANE_COUNT      = DEF_LANE_COUNT,
  parameter int BANK_COUNT      = DEF_BANK_COUNT,
  parameter int TILE_SIZE       = DEF_TILE_SIZE,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lane_valid          [LANE_COUNT],
  output logic                         lane_ready          [LANE_COUNT],
  input  logic [$clog2(TILE_SIZE)-1:0] lane_row            [LANE_COUNT],
  input  logic [$clog2(TILE_SIZE)-1:0] lane_column         [LANE_COUNT],
  input  logic [DATA_WIDTH-1:0]        lane_value          [LANE_COUNT],
  input  logic [$clog2(BANK_COUNT)-1:0] lane_bank          [LANE_COUNT],
  output logic [$clog2(TILE_SIZE)-1:0] buffer_row_write    [BANK_COUNT],
  output logic [$clog2(TILE_SIZE)-1:0] buffer_column_write [BANK_COUNT],
  output logic [DATA_WIDTH-1:0]        buffer_data_write   [BANK_COUNT],
  output logic                         buffer_write_enable [BANK_COUNT],
  input  logic                         drain_req,
  output logic                         drained,
  output logic [STALL_CNT_WIDTH-1:0]   stall_count
);

  localparam int LW = $clog2(LANE_COUNT);
  localparam int BW = $clog2(BANK_COUNT);
  localparam int RW = $clog2(TILE_SIZE);

  lane_entry_t                held_q   [LANE_COUNT];
  lane_entry_t                held_d   [LANE_COUNT];
  logic [LW-1:0]              rr_ptr_q [BANK_COUNT];
  logic [LW-1:0]              rr_ptr_d [BANK_COUNT];
  logic                       we_q     [BANK_COUNT];
  logic                       we_d     [BANK_COUNT];
  logic [RW-1:0]              row_q    [BANK_COUNT];
  logic [RW-1:0]              row_d    [BANK_COUNT];
  logic [RW-1:0]              col_q    [BANK_COUNT];
  logic [RW-1:0]              col_d    [BANK_COUNT];
  logic [DATA_WIDTH-1:0]      data_q   [BANK_COUNT];
  logic [DATA_WIDTH-1:0]      data_d   [BANK_COUNT];
  logic [STALL_CNT_WIDTH-1:0] stall_q;
  logic [STALL_CNT_WIDTH-1:0] stall_d;

  logic [LANE_COUNT-1:0] bank_req [BANK_COUNT];
  logic [LANE_COUNT-1:0] bank_gnt [BANK_COUNT];
  logic [LW-1:0]         bank_idx [BANK_COUNT];
  logic                  bank_any [BANK_COUNT];
  logic [LANE_COUNT-1:0] granted;
  logic                  stall_hit;

  // Drain is only a status request; acceptance is never gated by it.
  logic unused_drain_req;
  assign unused_drain_req = drain_req;

  // Per-bank request vectors from the holding registers.
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      bank_req[b] = '0;
      for (int i = 0; i < LANE_COUNT; i++) begin
        bank_req[b][i] = held_q[i].valid && (held_q[i].bank == BW'(b));
      end
    end
  end

  for (genvar gi = 0; gi < BANK_COUNT; gi++) begin : g_bank
    rr_arbiter #(.N(LANE_COUNT)) u_arb (
      .request      (bank_req[gi]),
      .pointer      (rr_ptr_q[gi]),
      .grant_onehot (bank_gnt[gi]),
      .grant_index  (bank_idx[gi]),
      .any_grant    (bank_any[gi])
    );
  end

  // A lane is granted if any bank picked it (at most one bank can).
  always_comb begin
    granted = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      granted = granted | bank_gnt[b];
    end
  end

  // Lane handshake, holding-register next state and stall detection.
  always_comb begin
    stall_hit = 1'b0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      lane_ready[i] = !held_q[i].valid || granted[i];
      held_d[i]     = held_q[i];
      if (granted[i]) begin
        held_d[i].valid = 1'b0;
      end
      if (lane_valid[i] && lane_ready[i]) begin
        held_d[i].valid  = 1'b1;
        held_d[i].row    = lane_row[i];
        held_d[i].column = lane_column[i];
        held_d[i].value  = lane_value[i];
        // Out-of-range banks (non-power-of-two bank counts) fold back in range.
        held_d[i].bank   = BW'(32'(lane_bank[i]) % BANK_COUNT);
      end
      if (held_q[i].valid && !granted[i]) begin
        stall_hit = 1'b1;
      end
    end
    stall_d = (stall_hit && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
  end

  // Bank write outputs and pointer advance; idle banks hold their fields.
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      rr_ptr_d[b] = rr_ptr_q[b];
      we_d[b]     = bank_any[b];
      row_d[b]    = row_q[b];
      col_d[b]    = col_q[b];
      data_d[b]   = data_q[b];
      if (bank_any[b]) begin
        rr_ptr_d[b] = LW'((int'(bank_idx[b]) + 1) % LANE_COUNT);
        row_d[b]    = held_q[bank_idx[b]].row;
        col_d[b]    = held_q[bank_idx[b]].column;
        data_d[b]   = held_q[bank_idx[b]].value;
      end
    end
  end

  // Status and output mapping.
  always_comb begin
    drained = 1'b1;
    for (int i = 0; i < LANE_COUNT; i++) begin
      if (held_q[i].valid) drained = 1'b0;
    end
    for (int b = 0; b < BANK_COUNT; b++) begin
      if (we_q[b]) drained = 1'b0;
      buffer_write_enable[b] = we_q[b];
      buffer_row_write[b]    = row_q[b];
      buffer_column_write[b] = col_q[b];
      buffer_data_write[b]   = data_q[b];
    end
    stall_count = stall_q;
  end

  // State registers; reset discards held products and clears outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANE_COUNT; i++) held_q[i] <= '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
        rr_ptr_q[b] <= '0;
        we_q[b]     <= 1'b0;
        row_q[b]    <= '0;
        col_q[b]    <= '0;
        data_q[b]   <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int i = 0; i < LANE_COUNT; i++) held_q[i] <= held_d[i];
      for (int b = 0; b < BANK_COUNT; b++) begin
        rr_ptr_q[b] <= rr_ptr_d[b];
        we_q[b]     <= we_d[b];
        row_q[b]    <= row_d[b];
        col_q[b]    <= col_d[b];
        data_q[b]   <= data_d[b];
      end
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_accumulator_write_arbiter.sv
// Self-checking bench for accumulator_write_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_accumulator_write_arbiter;

  localparam int LN   = 8;
  localparam int BN   = 32;
  localparam int RW   = 7;
  localparam int DW   = 8;
  localparam int BKW  = 5;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           lane_valid [LN];
  logic           lane_ready [LN];
  logic [RW-1:0]  lane_row [LN];
  logic [RW-1:0]  lane_column [LN];
  logic [DW-1:0]  lane_value [LN];
  logic [BKW-1:0] lane_bank [LN];
  logic [RW-1:0]  buffer_row_write [BN];
  logic [RW-1:0]  buffer_column_write [BN];
  logic [DW-1:0]  buffer_data_write [BN];
  logic           buffer_write_enable [BN];
  logic           drain_req;
  logic           drained;
  logic [SW-1:0]  stall_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  accumulator_write_arbiter #(
    .LANE_COUNT(LN), .BANK_COUNT(BN), .TILE_SIZE(128), .DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .lane_valid(lane_valid), .lane_ready(lane_ready),
    .lane_row(lane_row), .lane_column(lane_column),
    .lane_value(lane_value), .lane_bank(lane_bank),
    .buffer_row_write(buffer_row_write), .buffer_column_write(buffer_column_write),
    .buffer_data_write(buffer_data_write), .buffer_write_enable(buffer_write_enable),
    .drain_req(drain_req), .drained(drained), .stall_count(stall_count)
  );

  // ---------------- reference model (transaction level) ----------------
  typedef struct { bit v; int row; int col; int val; int bank; } ment_t;
  ment_t m_held [LN];
  int    m_ptr [BN];
  int    m_win [BN];
  bit    m_gr [LN];
  bit    m_we [BN];
  int    m_row [BN];
  int    m_col [BN];
  int    m_dat [BN];
  int    m_stall;
  bit    exp_ready [LN];
  bit    cap_ready [LN];

  function automatic void model_reset();
    for (int i = 0; i < LN; i++) m_held[i] = '{0, 0, 0, 0, 0};
    for (int b = 0; b < BN; b++) begin
      m_ptr[b] = 0; m_we[b] = 0; m_row[b] = 0; m_col[b] = 0; m_dat[b] = 0;
    end
    m_stall = 0;
  endfunction

  // Winner per bank = held requester with the smallest forward distance from the pointer.
  function automatic void model_grants();
    for (int i = 0; i < LN; i++) m_gr[i] = 0;
    for (int b = 0; b < BN; b++) begin
      int best_d;
      m_win[b] = -1;
      best_d = LN;
      for (int i = 0; i < LN; i++) begin
        if (m_held[i].v && m_held[i].bank == b && ((i - m_ptr[b] + LN) % LN) < best_d) begin
          best_d = (i - m_ptr[b] + LN) % LN;
          m_win[b] = i;
        end
      end
      if (m_win[b] >= 0) m_gr[m_win[b]] = 1;
    end
  endfunction

  function automatic void model_edge();
    bit loss;
    loss = 0;
    model_grants();
    for (int b = 0; b < BN; b++) begin
      m_we[b] = (m_win[b] >= 0);
      if (m_win[b] >= 0) begin
        m_row[b] = m_held[m_win[b]].row;
        m_col[b] = m_held[m_win[b]].col;
        m_dat[b] = m_held[m_win[b]].val;
        m_ptr[b] = (m_win[b] + 1) % LN;
      end
    end
    for (int i = 0; i < LN; i++) if (m_held[i].v && !m_gr[i]) loss = 1;
    if (loss && m_stall < SMAX) m_stall++;
    for (int i = 0; i < LN; i++) begin
      if (lane_valid[i] && (!m_held[i].v || m_gr[i]))
        m_held[i] = '{1, int'(lane_row[i]), int'(lane_column[i]), int'(lane_value[i]), int'(lane_bank[i]) % BN};
      else if (m_gr[i])
        m_held[i].v = 0;
    end
  endfunction

  function automatic bit model_drained();
    bit d;
    d = 1;
    for (int i = 0; i < LN; i++) if (m_held[i].v) d = 0;
    for (int b = 0; b < BN; b++) if (m_we[b]) d = 0;
    return d;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_lanes();
    for (int i = 0; i < LN; i++) begin
      lane_valid[i] = 0; lane_row[i] = '0; lane_column[i] = '0; lane_value[i] = '0; lane_bank[i] = '0;
    end
  endtask

  task automatic set_lane(input int i, input int row, input int col, input int val, input int bank);
    lane_valid[i]  = 1;
    lane_row[i]    = RW'(row);
    lane_column[i] = RW'(col);
    lane_value[i]  = DW'(val);
    lane_bank[i]   = BKW'(bank);
  endtask

  // One clock: capture ready before the edge, advance the model at the edge,
  // return on the falling edge with registered outputs settled.
  task automatic tick();
    #1;
    model_grants();
    for (int i = 0; i < LN; i++) begin
      exp_ready[i] = !m_held[i].v || m_gr[i];
      cap_ready[i] = lane_ready[i];
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    for (int b = 0; b < BN; b++)
      if (buffer_write_enable[b] === 1'b1)
        $display("cyc=%0d write bank=%0d row=%0d col=%0d data=%02h", cyc, b,
                 buffer_row_write[b], buffer_column_write[b], buffer_data_write[b]);
  endtask

  task automatic apply_reset();
    reset = 1;
    clear_lanes();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    drain_req = 0;
    clear_lanes();
    model_reset();
    @(negedge clk);
    #2;
    for (int i = 0; i < LN; i++) begin
      checks++;
      if (lane_ready[i] !== 1'b1) begin failures++; $display("FAIL reset_ready lane=%0d got=%b exp=1", i, lane_ready[i]); end
    end
    for (int b = 0; b < BN; b++) begin
      checks++;
      if (buffer_write_enable[b] !== 1'b0 || buffer_row_write[b] !== '0 || buffer_column_write[b] !== '0 || buffer_data_write[b] !== '0) begin
        failures++;
        $display("FAIL reset_outputs bank=%0d got we=%b r=%0d c=%0d d=%h exp all 0", b,
                 buffer_write_enable[b], buffer_row_write[b], buffer_column_write[b], buffer_data_write[b]);
      end
    end
    checks++;
    if (drained !== 1'b1 || stall_count !== '0) begin failures++; $display("FAIL reset_status got drained=%b stall=%0d exp drained=1 stall=0", drained, stall_count); end
    @(negedge clk);
    reset = 0;
    tick();
    checks++;
    if (drained !== 1'b1 || lane_ready[0] !== 1'b1) begin failures++; $display("FAIL post_reset got drained=%b ready0=%b exp 1/1", drained, lane_ready[0]); end
  endtask

  task automatic test_single();
    apply_reset();
    set_lane(0, 3, 5, 'h11, 4);
    tick();
    clear_lanes();
    checks++;
    if (buffer_write_enable[4] !== 1'b0 || drained !== 1'b0) begin failures++; $display("FAIL single_accept got we4=%b drained=%b exp 0/0", buffer_write_enable[4], drained); end
    tick();
    checks++;
    if (buffer_write_enable[4] !== 1'b1 || buffer_row_write[4] !== 7'd3 || buffer_column_write[4] !== 7'd5 || buffer_data_write[4] !== 8'h11) begin
      failures++;
      $display("FAIL single_write got we=%b r=%0d c=%0d d=%h exp we=1 r=3 c=5 d=11", buffer_write_enable[4], buffer_row_write[4], buffer_column_write[4], buffer_data_write[4]);
    end
    for (int b = 0; b < BN; b++) begin
      if (b != 4) begin
        checks++;
        if (buffer_write_enable[b] !== 1'b0) begin failures++; $display("FAIL single_other_we bank=%0d got=%b exp=0", b, buffer_write_enable[b]); end
      end
    end
    tick();
    checks++;
    if (buffer_write_enable[4] !== 1'b0 || drained !== 1'b1 || buffer_row_write[4] !== 7'd3 || buffer_data_write[4] !== 8'h11) begin
      failures++;
      $display("FAIL single_after got we=%b drained=%b r=%0d d=%h exp we=0 drained=1 r=3 d=11", buffer_write_enable[4], drained, buffer_row_write[4], buffer_data_write[4]);
    end
  endtask

  task automatic test_parallel();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < LN; i++) set_lane(i, $urandom_range(127), $urandom_range(127), $urandom_range(255), i);
      tick();
      for (int i = 0; i < LN; i++) begin
        checks++;
        if (cap_ready[i] !== 1'b1) begin failures++; $display("FAIL parallel_ready cyc=%0d lane=%0d got=%b exp=1", c, i, cap_ready[i]); end
      end
      if (c >= 1) begin
        for (int b = 0; b < LN; b++) begin
          checks++;
          if (buffer_write_enable[b] !== 1'b1 || buffer_data_write[b] !== DW'(m_dat[b]) || buffer_row_write[b] !== RW'(m_row[b]) || buffer_column_write[b] !== RW'(m_col[b])) begin
            failures++;
            $display("FAIL parallel_write cyc=%0d bank=%0d got we=%b d=%h exp we=1 d=%h", c, b, buffer_write_enable[b], buffer_data_write[b], DW'(m_dat[b]));
          end
        end
      end
      checks++;
      if (stall_count !== '0) begin failures++; $display("FAIL parallel_stall got=%0d exp=0", stall_count); end
    end
    clear_lanes();
    tick();
    tick();
    checks++;
    if (drained !== 1'b1) begin failures++; $display("FAIL parallel_drained got=%b exp=1", drained); end
  endtask

  task automatic test_full_conflict();
    apply_reset();
    for (int i = 0; i < 4; i++) set_lane(i, i, 10 + i, 'hA0 + i, 9);
    tick();
    clear_lanes();
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (cap_ready[j] !== (j <= k)) begin failures++; $display("FAIL conflict_ready step=%0d lane=%0d got=%b exp=%b", k, j, cap_ready[j], (j <= k)); end
      end
      checks++;
      if (buffer_write_enable[9] !== 1'b1 || buffer_data_write[9] !== DW'('hA0 + k) || buffer_row_write[9] !== RW'(k)) begin
        failures++;
        $display("FAIL conflict_order step=%0d got we=%b d=%h r=%0d exp we=1 d=%h r=%0d", k, buffer_write_enable[9], buffer_data_write[9], buffer_row_write[9], DW'('hA0 + k), k);
      end
    end
    checks++;
    if (stall_count !== SW'(3)) begin failures++; $display("FAIL conflict_stall got=%0d exp=3", stall_count); end
    tick();
    checks++;
    if (buffer_write_enable[9] !== 1'b0 || drained !== 1'b1) begin failures++; $display("FAIL conflict_end got we=%b drained=%b exp 0/1", buffer_write_enable[9], drained); end
  endtask

  task automatic test_fairness();
    int run1, run2;
    run1 = 0;
    run2 = 0;
    apply_reset();
    set_lane(1, 1, 1, 'h01, 0);
    set_lane(2, 2, 2, 'h02, 0);
    for (int n = 0; n < 12; n++) begin
      tick();
      run1 = cap_ready[1] ? 0 : run1 + 1;
      run2 = cap_ready[2] ? 0 : run2 + 1;
      checks++;
      if (run1 > 1 || run2 > 1) begin failures++; $display("FAIL fairness_stall n=%0d got runs=%0d/%0d exp <=1", n, run1, run2); end
      if (n >= 1) begin
        checks++;
        if (buffer_write_enable[0] !== 1'b1 || buffer_data_write[0] !== ((n % 2 == 1) ? 8'h01 : 8'h02)) begin
          failures++;
          $display("FAIL fairness_order n=%0d got we=%b d=%h exp we=1 d=%h", n, buffer_write_enable[0], buffer_data_write[0], (n % 2 == 1) ? 8'h01 : 8'h02);
        end
      end
    end
    checks++;
    if (stall_count !== SW'(m_stall)) begin failures++; $display("FAIL fairness_stall_count got=%0d exp=%0d", stall_count, m_stall); end
    clear_lanes();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) set_lane(i, i, i, 'h50 + i, 5);
    tick();
    clear_lanes();
    tick();
    checks++;
    if (buffer_write_enable[5] !== 1'b1 || buffer_data_write[5] !== 8'h50) begin failures++; $display("FAIL midreset_pre got we=%b d=%h exp 1/50", buffer_write_enable[5], buffer_data_write[5]); end
    #2 reset = 1;
    #1;
    model_reset();
    checks++;
    if (buffer_write_enable[5] !== 1'b0 || drained !== 1'b1 || stall_count !== '0) begin
      failures++;
      $display("FAIL midreset_async got we=%b drained=%b stall=%0d exp 0/1/0", buffer_write_enable[5], drained, stall_count);
    end
    for (int i = 0; i < LN; i++) begin
      checks++;
      if (lane_ready[i] !== 1'b1) begin failures++; $display("FAIL midreset_ready lane=%0d got=%b exp=1", i, lane_ready[i]); end
    end
    @(negedge clk);
    reset = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      for (int b = 0; b < BN; b++) begin
        checks++;
        if (buffer_write_enable[b] !== 1'b0) begin failures++; $display("FAIL midreset_nowrite n=%0d bank=%0d got=%b exp=0", n, b, buffer_write_enable[b]); end
      end
    end
    set_lane(0, 0, 0, 'hC0, 5);
    set_lane(7, 7, 7, 'hC7, 5);
    tick();
    clear_lanes();
    tick();
    checks++;
    if (buffer_write_enable[5] !== 1'b1 || buffer_data_write[5] !== 8'hC0) begin failures++; $display("FAIL midreset_ptr0 got we=%b d=%h exp 1/c0", buffer_write_enable[5], buffer_data_write[5]); end
    tick();
    checks++;
    if (buffer_write_enable[5] !== 1'b1 || buffer_data_write[5] !== 8'hC7) begin failures++; $display("FAIL midreset_second got we=%b d=%h exp 1/c7", buffer_write_enable[5], buffer_data_write[5]); end
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    set_lane(0, 1, 1, 'h0A, 2);
    set_lane(1, 2, 2, 'h0B, 2);
    for (int n = 0; n < (1 << SW) + 6; n++) begin
      tick();
      checks++;
      if (stall_count !== SW'(m_stall)) begin failures++; $display("FAIL sat_track n=%0d got=%0d exp=%0d", n, stall_count, m_stall); end
    end
    checks++;
    if (stall_count !== SW'(SMAX)) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", stall_count, SMAX); end
    clear_lanes();
    tick();
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < LN; i++) begin
        if ($urandom_range(99) < 60)
          set_lane(i, $urandom_range(127), $urandom_range(127), $urandom_range(255),
                   ($urandom_range(1) == 1) ? $urandom_range(3) : $urandom_range(BN - 1));
        else
          lane_valid[i] = 0;
      end
      tick();
      for (int i = 0; i < LN; i++) begin
        checks++;
        if (cap_ready[i] !== exp_ready[i]) begin failures++; $display("FAIL random_ready c=%0d lane=%0d got=%b exp=%b", c, i, cap_ready[i], exp_ready[i]); end
      end
      for (int b = 0; b < BN; b++) begin
        checks++;
        if (buffer_write_enable[b] !== m_we[b] || buffer_row_write[b] !== RW'(m_row[b]) || buffer_column_write[b] !== RW'(m_col[b]) || buffer_data_write[b] !== DW'(m_dat[b])) begin
          failures++;
          $display("FAIL random_write c=%0d bank=%0d got we=%b r=%0d c=%0d d=%h exp we=%b r=%0d c=%0d d=%h", c, b,
                   buffer_write_enable[b], buffer_row_write[b], buffer_column_write[b], buffer_data_write[b],
                   m_we[b], m_row[b], m_col[b], DW'(m_dat[b]));
        end
      end
      checks++;
      if (drained !== model_drained() || stall_count !== SW'(m_stall)) begin
        failures++;
        $display("FAIL random_status c=%0d got drained=%b stall=%0d exp drained=%b stall=%0d", c, drained, stall_count, model_drained(), m_stall);
      end
    end
    clear_lanes();
    drain_req = 1;
    for (int n = 0; n < 12; n++) tick();
    checks++;
    if (drained !== 1'b1) begin failures++; $display("FAIL random_drain got=%b exp=1", drained); end
    drain_req = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_parallel();
    test_full_conflict();
    test_fairness();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
